alu_seq: RTL and testbench

- Parametrised, handshaked successor to the team's 8-bit combinational ALU. Generalised to WIDTH bits with registered outputs and a 4-bit opcode.
- Adds arithmetic right shift, unsigned compare, a multi-cycle unsigned multiply, carry/negative flags and an illegal-op flag.
- Sits between the operand-issue stage and the writeback register. Valid/ready handshake on both sides, one operation in flight at a time.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_mul_iter.sv | 66 ++++++
 rtl/alu_seq.sv | 202 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: opcode encoding, FSM state
// encoding and the opcode width.
package alu_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned ST_W = 2;

  // Opcode encoding; values above OP_MUL are undefined and reported as illegal.
  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_SLL  = 4'd5;
  localparam logic [OP_W-1:0] OP_SRL  = 4'd6;
  localparam logic [OP_W-1:0] OP_SRA  = 4'd7;
  localparam logic [OP_W-1:0] OP_SLT  = 4'd8;
  localparam logic [OP_W-1:0] OP_SLTU = 4'd9;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd10;

  // FSM state encoding.
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_MULT = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_mul_iter.sv
// WIDTH-iteration unsigned shift-add multiplier.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_start         : load operands and begin (ignored bits of state are reloaded)
//   i_a, i_b        : unsigned multiplicand / multiplier
//   o_busy          : iterations in progress
//   o_done_c        : current edge performs the final iteration (combinational)
//   o_product_c     : accumulator value after the current edge's iteration (combinational)
module alu_mul_iter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_busy,
  output logic                 o_done_c,
  output logic [2*WIDTH-1:0]   o_product_c
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned PW  = 2 * WIDTH;

  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    r_acc;
  logic [WIDTH-1:0] r_mplier;
  logic [SHW-1:0]   r_cnt;
  logic             r_busy;
  logic [PW-1:0]    w_acc_nxt;
  logic             w_last;

  // One partial product per iteration, selected by the multiplier LSB.
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last    = r_busy && (r_cnt == SHW'(WIDTH - 1));

  // Iteration state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_acc    <= '0;
      r_mplier <= i_b;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + SHW'(1);
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done_c    = w_last;
  assign o_product_c = w_acc_nxt;

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ops complete in one cycle, MUL
// uses the iterative multiplier. One operation in flight at a time.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operation handshake (a, b, op captured on acceptance)
//   a, b, op            : operands and opcode; shift amount is b[SHW-1:0]
//   out_valid/out_ready : result handshake
//   result, zero, negative, carry, overflow, illegal : registered result and flags
module alu_seq
  import alu_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  logic [ST_W-1:0]    r_state;
  logic [ST_W-1:0]    w_state_nxt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_negative;
  logic               r_carry;
  logic               r_overflow;
  logic               r_illegal;

  logic               w_accept;
  logic               w_load_alu;
  logic               w_load_mul;
  logic               w_mul_start;
  logic               w_mul_busy;
  logic               w_mul_done_c;
  logic [2*WIDTH-1:0] w_mul_prod_c;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [SHW-1:0]     w_shamt;
  logic signed [WIDTH-1:0] w_sra;
  logic               w_slt;
  logic               w_sltu;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_carry;
  logic               w_alu_ovf;
  logic               w_alu_ill;

  assign w_accept = in_valid && r_in_ready;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_mul_start),
    .i_a         (a),
    .i_b         (b),
    .o_busy      (w_mul_busy),
    .o_done_c    (w_mul_done_c),
    .o_product_c (w_mul_prod_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and load strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load_alu  = 1'b0;
    w_load_mul  = 1'b0;
    w_mul_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (op == OP_MUL) begin
            w_state_nxt = ST_MULT;
            w_mul_start = 1'b1;
          end else begin
            w_state_nxt = ST_DONE;
            w_load_alu  = 1'b1;
          end
        end
      end
      ST_MULT: begin
        if (w_mul_done_c) begin
          w_state_nxt = ST_DONE;
          w_load_mul  = 1'b1;
        end else if (!w_mul_busy) begin
          // Multiplier lost its operation; recover rather than hang.
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_sum   = {1'b0, a} + {1'b0, b};
  assign w_diff  = a - b;
  assign w_shamt = b[SHW-1:0];
  assign w_sra   = $signed(a) >>> w_shamt;
  assign w_slt   = $signed(a) < $signed(b);
  assign w_sltu  = a < b;

  // Single-cycle datapath.
  always_comb begin
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    w_alu_ovf   = 1'b0;
    w_alu_ill   = 1'b0;
    case (op)
      OP_ADD: begin
        w_alu_res   = w_sum[WIDTH-1:0];
        w_alu_carry = w_sum[WIDTH];
        w_alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res   = w_diff;
        w_alu_carry = w_sltu;
        w_alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  w_alu_res = a & b;
      OP_OR:   w_alu_res = a | b;
      OP_XOR:  w_alu_res = a ^ b;
      OP_SLL:  w_alu_res = a << w_shamt;
      OP_SRL:  w_alu_res = a >> w_shamt;
      OP_SRA:  w_alu_res = w_sra;
      OP_SLT:  w_alu_res = WIDTH'(w_slt);
      OP_SLTU: w_alu_res = WIDTH'(w_sltu);
      default: w_alu_ill = 1'b1;
    endcase
  end

  // Handshake outputs follow the next state so they are valid from the first cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
    end
  end

  // Result and flags change only on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (w_load_alu) begin
      r_result   <= w_alu_res;
      r_zero     <= (w_alu_res == '0);
      r_negative <= w_alu_res[WIDTH-1];
      r_carry    <= w_alu_carry;
      r_overflow <= w_alu_ovf;
      r_illegal  <= w_alu_ill;
    end else if (w_load_mul) begin
      r_result   <= w_mul_prod_c[WIDTH-1:0];
      r_zero     <= (w_mul_prod_c[WIDTH-1:0] == '0);
      r_negative <= w_mul_prod_c[WIDTH-1];
      r_carry    <= |w_mul_prod_c[2*WIDTH-1:WIDTH];
      r_overflow <= 1'b0;
      r_illegal  <= 1'b0;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign negative  = r_negative;
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, handshake/reset
// sequences and randomized ops against an arithmetic reference model.
module tb_alu_seq;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;
  logic             illegal;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .negative  (negative),
    .carry     (carry),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // flags packed as {zero, negative, carry, overflow, illegal}
  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [4:0]  f;
  } vec_t;

  typedef struct {
    logic [15:0] r;
    logic [4:0]  f;
  } exp_t;

  function automatic logic [4:0] dut_flags();
    return {zero, negative, carry, overflow, illegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic meaning of each opcode.
  function automatic exp_t model(input int op_i, input int unsigned av, input int unsigned bv);
    exp_t e;
    int sa, sb, t, sh;
    int unsigned r;
    longint unsigned pa, pb, p;
    bit c, v, ill;
    sa = (av >= 32768) ? int'(av) - 65536 : int'(av);
    sb = (bv >= 32768) ? int'(bv) - 65536 : int'(bv);
    sh = int'(bv % 16);
    c = 0; v = 0; ill = 0; r = 0;
    case (op_i)
      0: begin r = av + bv; c = (r > 65535); t = sa + sb; v = (t > 32767) || (t < -32768); end
      1: begin r = av - bv; c = (av < bv);   t = sa - sb; v = (t > 32767) || (t < -32768); end
      2: r = av & bv;
      3: r = av | bv;
      4: r = av ^ bv;
      5: r = av << sh;
      6: r = av >> sh;
      7: r = 32'(sa >>> sh);
      8: r = (sa < sb) ? 1 : 0;
      9: r = (av < bv) ? 1 : 0;
      10: begin
        pa = 64'(av); pb = 64'(bv); p = pa * pb;
        r = 32'(p % 65536);
        c = (p > 65535);
      end
      default: ill = 1;
    endcase
    r = r & 32'h0000FFFF;
    e.r = 16'(r);
    e.f = {(r == 0), r[15], c, v, ill};
    return e;
  endfunction

  // Issue one op, check latency/result/flags; optionally hold out_ready low.
  task automatic run_op(input logic [3:0] op_i, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] er, input logic [4:0] ef, input int hold,
                        input string name);
    int waited;
    int lat;
    logic [15:0] held_r;
    logic [4:0]  held_f;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready && waited < 50);
    if (!in_ready) begin
      chk({name, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
      return;
    end
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    op = op_i; a = av; b = bv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    chk({name, "_latency"}, 32'(lat), (op_i == 4'd10) ? 32'(WIDTH + 1) : 32'd1);
    chk({name, "_result"}, 32'(result), 32'(er));
    chk({name, "_flags"}, 32'(dut_flags()), 32'(ef));
    if (hold > 0) begin
      held_r = result;
      held_f = dut_flags();
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        op = 4'd0; a = 16'h0F0F; b = 16'h0101;
        @(negedge clk);
        chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        chk({name, "_hold_result"}, 32'(result), 32'(held_r));
        chk({name, "_hold_flags"}, 32'(dut_flags()), 32'(held_f));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk({name, "_release_valid"}, 32'(out_valid), 32'd0);
      chk({name, "_release_in_ready"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      chk({name, "_ignored_op"}, 32'(out_valid), 32'd0);
    end
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'hFFFF;
      3: return 16'h8000;
      4: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  vec_t vecs[$];

  initial begin
    exp_t e;
    logic [3:0]  rop;
    logic [15:0] ra, rb;
    bit ov_seen;

    vecs.push_back('{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 5'b01010});
    vecs.push_back('{4'd1,  16'h0003, 16'h0005, 16'hFFFE, 5'b01100});
    vecs.push_back('{4'd1,  16'h8000, 16'h0001, 16'h7FFF, 5'b00010});
    vecs.push_back('{4'd10, 16'd300,  16'd200,  16'hEA60, 5'b01000});
    vecs.push_back('{4'd10, 16'd300,  16'd300,  16'h5F90, 5'b00100});
    vecs.push_back('{4'd7,  16'h8000, 16'h0004, 16'hF800, 5'b01000});
    vecs.push_back('{4'd6,  16'h8000, 16'h0004, 16'h0800, 5'b00000});
    vecs.push_back('{4'd8,  16'hFFFF, 16'h0001, 16'h0001, 5'b00000});
    vecs.push_back('{4'd9,  16'hFFFF, 16'h0001, 16'h0000, 5'b10000});
    vecs.push_back('{4'd12, 16'h1234, 16'h5678, 16'h0000, 5'b10001});
    vecs.push_back('{4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 5'b10001});
    vecs.push_back('{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 5'b10100});
    vecs.push_back('{4'd5,  16'h0001, 16'h000F, 16'h8000, 5'b01000});
    vecs.push_back('{4'd5,  16'h1234, 16'h0010, 16'h1234, 5'b00000});
    vecs.push_back('{4'd2,  16'hF0F0, 16'hFF00, 16'hF000, 5'b01000});
    vecs.push_back('{4'd3,  16'h00F0, 16'h0F00, 16'h0FF0, 5'b00000});
    vecs.push_back('{4'd4,  16'hAAAA, 16'hAAAA, 16'h0000, 5'b10000});
    vecs.push_back('{4'd10, 16'hFFFF, 16'hFFFF, 16'h0001, 5'b00100});
    vecs.push_back('{4'd10, 16'h0000, 16'h1234, 16'h0000, 5'b10000});

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_flags", 32'(dut_flags()), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].f, 0, $sformatf("vec%0d", i));
    end

    run_op(4'd0, 16'h1234, 16'h0101, 16'h1335, 5'b00000, 5, "hold");

    // Reset in the middle of a multiply must abort it silently.
    while (!in_ready) @(negedge clk);
    in_valid = 1'b1; op = 4'd10; a = 16'd300; b = 16'd300;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midmul_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midmul_rst_in_ready", 32'(in_ready), 32'd0);
    chk("midmul_rst_result", 32'(result), 32'd0);
    chk("midmul_rst_flags", 32'(dut_flags()), 32'd0);
    rst = 1'b0;
    ov_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) ov_seen = 1;
    end
    chk("midmul_no_output", 32'(ov_seen), 32'd0);
    chk("midmul_idle_ready", 32'(in_ready), 32'd1);
    run_op(4'd10, 16'd300, 16'd200, 16'hEA60, 5'b01000, 0, "post_abort_mul");

    for (int n = 0; n < 250; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra = pick();
      rb = pick();
      e = model(int'(rop), 32'(ra), 32'(rb));
      run_op(rop, ra, rb, e.r, e.f, 0, $sformatf("rand%0d_op%0d", n, rop));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
